// File: rtl/jtdsp16.sv
// Small DSP16-style core: 4Kx16 program RAM, single-issue fetch/execute with async RAM read.
// One instruction per enabled cycle (two for long-immediate and y=*rX); cen=0 freezes all state.
module jtdsp16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    output logic [15:0] ext_addr,
    input  logic [15:0] ext_data,
    input  logic [11:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic        prog_we
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_LIMM = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    localparam logic [4:0] T_LIMM = 5'b01010;
    localparam logic [4:0] T_LOAD = 5'b00111;
    localparam logic [4:0] T_ALU  = 5'b00100;
    localparam logic [4:0] T_RET  = 5'b11000;

    state_t      state, state_nxt;
    logic [15:0] ram [0:4095];
    logic [11:0] pc, pr;
    logic [15:0] r [0:3];
    logic [15:0] j, y;
    logic [35:0] a0, a1;
    logic [1:0]  ld_x, ld_mod;
    logic [2:0]  li_dst;

    logic [4:0]  op_t;
    logic [11:0] op_tgt;
    logic [2:0]  op_sub;
    logic [2:0]  op_dst;
    logic [1:0]  op_x, op_mod;
    logic [15:0] op_word;

    logic [35:0] alu_acc, alu_p, alu_res;
    logic [15:0] pm_val;

    always_ff @(posedge clk) begin
        if (cen && prog_we)
            ram[prog_addr] <= prog_data;
    end

    // In S_LIMM pc already points at the immediate word, so the same read port serves both.
    assign op_word = ram[pc];
    assign op_t    = op_word[15:11];
    assign op_tgt  = op_word[11:0];
    assign op_sub  = op_word[10:8];
    assign op_dst  = op_word[6:4];
    assign op_x    = op_word[5:4];
    assign op_mod  = op_word[1:0];

    assign alu_acc = op_sub[2] ? a1 : a0;
    assign alu_p   = {{4{y[15]}}, y, 16'h0000};

    always_comb begin
        alu_res = '0;
        case (op_sub[1:0])
            2'b00:   alu_res = alu_p;
            2'b01:   alu_res = alu_acc + alu_p;
            2'b10:   alu_res = alu_acc - alu_p;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        pm_val = r[ld_x];
        case (ld_mod)
            2'b01:   pm_val = r[ld_x] + 16'd1;
            2'b10:   pm_val = r[ld_x] - 16'd1;
            2'b11:   pm_val = r[ld_x] + j;
            default: pm_val = r[ld_x];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (op_t == T_LIMM)
                    state_nxt = S_LIMM;
                else if (op_t == T_LOAD)
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            if (rst)
                state <= S_RUN;
            else
                state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            if (rst) begin
                pc       <= '0;
                pr       <= '0;
                j        <= '0;
                y        <= '0;
                a0       <= '0;
                a1       <= '0;
                ext_addr <= '0;
                ld_x     <= '0;
                ld_mod   <= '0;
                li_dst   <= '0;
                for (int i = 0; i < 4; i++)
                    r[i] <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        pc <= pc + 12'd1;
                        if (op_t[4:1] == 4'b0000) begin
                            pc <= op_tgt;
                        end else if (op_t[4:1] == 4'b1000) begin
                            pr <= pc + 12'd1;
                            pc <= op_tgt;
                        end else if (op_t == T_RET) begin
                            if (op_sub == 3'b000)
                                pc <= pr;
                        end else if (op_t == T_LIMM) begin
                            li_dst <= op_dst;
                        end else if (op_t == T_LOAD) begin
                            // pc holds here; it advances when the data returns
                            pc       <= pc;
                            ext_addr <= r[op_x];
                            ld_x     <= op_x;
                            ld_mod   <= op_mod;
                        end else if (op_t == T_ALU) begin
                            if (op_sub[2])
                                a1 <= alu_res;
                            else
                                a0 <= alu_res;
                        end
                    end
                    S_LIMM: begin
                        pc <= pc + 12'd1;
                        case (li_dst)
                            3'd0, 3'd1, 3'd2, 3'd3: r[li_dst[1:0]] <= op_word;
                            3'd4:    j  <= op_word;
                            3'd5:    pr <= op_word[11:0];
                            3'd6:    y  <= op_word;
                            default: ;
                        endcase
                    end
                    S_LOAD: begin
                        pc       <= pc + 12'd1;
                        y        <= ext_data;
                        r[ld_x]  <= pm_val;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16.sv
// Bench for jtdsp16: directed program checks plus random programs against an instruction-level model.
module tb_jtdsp16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic [15:0] ext_addr;
    logic [15:0] ext_data;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;
    logic        prog_we;

    int checks = 0;
    int errors = 0;

    jtdsp16 dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we)
    );

    always #5 clk = ~clk;

    // Instruction-level reference model
    logic [15:0] m_mem [0:4095];
    logic [11:0] m_pc, m_pr;
    logic [15:0] m_r [0:3];
    logic [15:0] m_j, m_y, m_ea;
    logic [35:0] m_a0, m_a1;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic en_cycle();
        cen = 1'b1;
        tick();
    endtask

    task automatic idle_cycle();
        cen = 1'b0;
        tick();
    endtask

    task automatic m_reset();
        m_pc = '0; m_pr = '0; m_j = '0; m_y = '0; m_ea = '0;
        m_a0 = '0; m_a1 = '0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [15:0] d);
        rst = 1'b1; prog_we = 1'b1; prog_addr = a; prog_data = d;
        en_cycle();
        prog_we = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en_cycle();
        en_cycle();
        rst = 1'b0;
        m_reset();
    endtask

    task automatic m_exec(input logic [15:0] ed, output int ncyc);
        logic [15:0] w, imm;
        logic [1:0]  x;
        longint      sp, acc;
        w = m_mem[m_pc];
        ncyc = 1;
        if (w[15:12] == 4'b0000) begin
            m_pc = w[11:0];
        end else if (w[15:12] == 4'b1000) begin
            m_pr = m_pc + 12'd1;
            m_pc = w[11:0];
        end else if (w[15:11] == 5'b11000 && w[10:8] == 3'b000) begin
            m_pc = m_pr;
        end else if (w[15:11] == 5'b01010) begin
            imm = m_mem[m_pc + 12'd1];
            case (w[6:4])
                3'd0: m_r[0] = imm;
                3'd1: m_r[1] = imm;
                3'd2: m_r[2] = imm;
                3'd3: m_r[3] = imm;
                3'd4: m_j    = imm;
                3'd5: m_pr   = imm[11:0];
                3'd6: m_y    = imm;
                default: ;
            endcase
            m_pc = m_pc + 12'd2;
            ncyc = 2;
        end else if (w[15:11] == 5'b00111) begin
            x = w[5:4];
            m_ea = m_r[x];
            m_y  = ed;
            if (w[1:0] == 2'b01) m_r[x] = m_r[x] + 16'd1;
            else if (w[1:0] == 2'b10) m_r[x] = m_r[x] - 16'd1;
            else if (w[1:0] == 2'b11) m_r[x] = m_r[x] + m_j;
            m_pc = m_pc + 12'd1;
            ncyc = 2;
        end else if (w[15:11] == 5'b00100) begin
            sp  = longint'($signed(m_y)) * 65536;
            acc = w[10] ? longint'(m_a1) : longint'(m_a0);
            case (w[9:8])
                2'b00: acc = sp;
                2'b01: acc = acc + sp;
                2'b10: acc = acc - sp;
                default: acc = 0;
            endcase
            if (w[10]) m_a1 = acc[35:0]; else m_a0 = acc[35:0];
            m_pc = m_pc + 12'd1;
        end else begin
            m_pc = m_pc + 12'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 36'(dut.pc), 36'(m_pc));
        chk({tag, ".pr"}, 36'(dut.pr), 36'(m_pr));
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s.r%0d", tag, i), 36'(dut.r[i]), 36'(m_r[i]));
        chk({tag, ".j"},  36'(dut.j),  36'(m_j));
        chk({tag, ".y"},  36'(dut.y),  36'(m_y));
        chk({tag, ".a0"}, dut.a0, m_a0);
        chk({tag, ".a1"}, dut.a1, m_a1);
        chk({tag, ".ea"}, 36'(ext_addr), 36'(m_ea));
    endtask

    task automatic run_instr(input string tag);
        logic [15:0] ed;
        int n;
        ed = 16'($urandom);
        ext_data = ed;
        m_exec(ed, n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) idle_cycle();
            en_cycle();
        end
        check_all(tag);
    endtask

    function automatic logic [15:0] gen_word();
        logic [15:0] rw;
        rw = 16'($urandom);
        case ($urandom_range(0, 9))
            0:       return {4'b0000, rw[11:0]};
            1:       return {4'b1000, rw[11:0]};
            2:       return {5'b11000, 3'b000, rw[7:0]};
            3:       return {5'b01010, rw[10:0]};
            4, 5:    return {5'b00111, rw[10:0]};
            6, 7:    return {5'b00100, rw[10:0]};
            default: return rw;
        endcase
    endfunction

    initial begin
        rst = 1'b1; cen = 1'b1; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; ext_data = '0;
        m_reset();
        tick(); tick();
        check_all("reset");

        // goto self loop; a cen=0 write attempt must not land in RAM
        load_word(12'h000, 16'h0005);
        load_word(12'h005, 16'h0005);
        prog_we = 1'b1; prog_addr = 12'h005; prog_data = 16'h0000;
        idle_cycle();
        prog_we = 1'b0;
        do_reset();
        en_cycle();
        chk("goto.pc1", 36'(dut.pc), 36'h005);
        en_cycle();
        chk("goto.pc2", 36'(dut.pc), 36'h005);
        en_cycle();
        chk("goto.pc3", 36'(dut.pc), 36'h005);
        chk("goto.ea", 36'(ext_addr), 36'h0);

        // long immediate then y=*r0 with post-increment
        load_word(12'h000, 16'h5000);
        load_word(12'h001, 16'h1234);
        load_word(12'h002, 16'h3801);
        do_reset();
        en_cycle();
        chk("limm.mid_pc", 36'(dut.pc), 36'h001);
        en_cycle();
        chk("limm.r0", 36'(dut.r[0]), 36'h1234);
        chk("limm.pc", 36'(dut.pc), 36'h002);
        ext_data = 16'hBEEF;
        en_cycle();
        chk("ld.ea", 36'(ext_addr), 36'h1234);
        en_cycle();
        chk("ld.y", 36'(dut.y), 36'hBEEF);
        chk("ld.r0", 36'(dut.r[0]), 36'h1235);
        chk("ld.pc", 36'(dut.pc), 36'h003);

        // same program again (RAM retained across reset) with a 3-cycle cen stall
        do_reset();
        chk("rst2.r0", 36'(dut.r[0]), 36'h0);
        chk("rst2.pc", 36'(dut.pc), 36'h0);
        en_cycle(); en_cycle(); en_cycle();
        repeat (3) idle_cycle();
        chk("stall.ea", 36'(ext_addr), 36'h1234);
        chk("stall.y", 36'(dut.y), 36'h0);
        chk("stall.r0", 36'(dut.r[0]), 36'h1234);
        chk("stall.pc", 36'(dut.pc), 36'h002);
        en_cycle();
        chk("stall.y2", 36'(dut.y), 36'hBEEF);
        chk("stall.r0b", 36'(dut.r[0]), 36'h1235);
        chk("stall.pc2", 36'(dut.pc), 36'h003);

        // accumulator sequence with y=1
        load_word(12'h000, 16'h5060);
        load_word(12'h001, 16'h0001);
        load_word(12'h002, 16'h2100);
        load_word(12'h003, 16'h2100);
        load_word(12'h004, 16'h2200);
        load_word(12'h005, 16'h2300);
        do_reset();
        en_cycle(); en_cycle();
        chk("alu.y", 36'(dut.y), 36'h1);
        en_cycle();
        chk("alu.add1", dut.a0, 36'h0_0001_0000);
        en_cycle();
        chk("alu.add2", dut.a0, 36'h0_0002_0000);
        en_cycle();
        chk("alu.sub", dut.a0, 36'h0_0001_0000);
        en_cycle();
        chk("alu.clr", dut.a0, 36'h0);
        chk("alu.a1", dut.a1, 36'h0);

        // call / return
        load_word(12'h000, 16'h8010);
        load_word(12'h010, 16'hC000);
        do_reset();
        chk("call.pc0", 36'(dut.pc), 36'h000);
        en_cycle();
        chk("call.pc", 36'(dut.pc), 36'h010);
        chk("call.pr", 36'(dut.pr), 36'h001);
        en_cycle();
        chk("ret.pc", 36'(dut.pc), 36'h001);
        chk("ret.pr", 36'(dut.pr), 36'h001);

        // random program over the whole RAM, with a mid-run reset
        for (int a = 0; a < 4096; a++)
            load_word(12'(a), gen_word());
        do_reset();
        check_all("rnd_start");
        for (int n = 0; n < 250; n++)
            run_instr("rnd");
        rst = 1'b1;
        en_cycle();
        rst = 1'b0;
        m_reset();
        check_all("rnd_rst");
        for (int n = 0; n < 250; n++)
            run_instr("rnd2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
